// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch/decode decoupling queue.
package fetch_decode_queue_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] word_t;

   // PC presented on the output side while the queue holds nothing.
   localparam addr_t DEFAULT_RESET_PC = 32'hbfc00000;

   // Sequential PC of a head entry; wraps modulo 2^32.
   function automatic addr_t pc_plus4(input addr_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_decode_queue_ptr.sv
// Wrap-bit pointer counter: one extra MSB distinguishes full from empty.
module fetch_decode_queue_ptr #(
   parameter int unsigned W = 3
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_q;
   logic [W-1:0] ptr_d;

   // Next pointer: clear wins over increment; natural wrap modulo 2^W.
   always_comb begin
      ptr_d = ptr_q;
      if (clr) begin
         ptr_d = '0;
      end else if (inc) begin
         ptr_d = ptr_q + W'(1);
      end
   end

   // Pointer register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch->decode decoupling queue with valid/ready on both sides and whole-queue flush.
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TAG_W    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_instr,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_pcplus4,
   output logic [31:0]                out_instr,
   output logic [TAG_W-1:0]           out_tag,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef struct packed {
      addr_t            pc;
      word_t            instr;
      logic [TAG_W-1:0] tag;
   } fdq_entry_t;

   fdq_entry_t mem [DEPTH];
   fdq_entry_t head;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // in_ready is purely state-derived: no pass-through when full.
   assign in_ready  = !full;
   assign out_valid = !empty;

   // A flush squashes any handshake in the same cycle.
   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

   assign count = CW'(wr_ptr - rd_ptr);

   fetch_decode_queue_ptr #(
      .W (PW)
   ) u_wr_ptr (
      .clk    (clk),
      .resetn (resetn),
      .clr    (flush),
      .inc    (push),
      .ptr    (wr_ptr)
   );

   fetch_decode_queue_ptr #(
      .W (PW)
   ) u_rd_ptr (
      .clk    (clk),
      .resetn (resetn),
      .clr    (flush),
      .inc    (pop),
      .ptr    (rd_ptr)
   );

   // Storage write at the tail; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (resetn && push) begin
         mem[wr_ptr[AW-1:0]] <= '{pc: in_pc, instr: in_instr, tag: in_tag};
      end
   end

   assign head = mem[rd_ptr[AW-1:0]];

   // Head view; constant defaults while empty so decode sees a stable PC.
   always_comb begin
      out_pc    = RESET_PC;
      out_instr = '0;
      out_tag   = '0;
      if (!empty) begin
         out_pc    = head.pc;
         out_instr = head.instr;
         out_tag   = head.tag;
      end
      out_pcplus4 = pc_plus4(out_pc);
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue with a queue-based reference model.
module tb_fetch_decode_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 4;
   localparam logic [31:0] RPC   = 32'hbfc00000;

   typedef struct {
      logic [31:0]      pc;
      logic [31:0]      instr;
      logic [TAG_W-1:0] tag;
   } ent_t;

   logic             clk;
   logic             resetn;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_pc;
   logic [31:0]      in_instr;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [31:0]      out_pcplus4;
   logic [31:0]      out_instr;
   logic [TAG_W-1:0] out_tag;
   logic [2:0]       count;

   int   checks;
   int   errors;
   bit   check_en;
   ent_t sb[$];

   fetch_decode_queue #(
      .DEPTH    (DEPTH),
      .TAG_W    (TAG_W),
      .RESET_PC (RPC)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_instr    (in_instr),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_pcplus4 (out_pcplus4),
      .out_instr   (out_instr),
      .out_tag     (out_tag),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Instruction/tag derived from the PC so the model never reads the DUT.
   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'h5a5a_0013;
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
      return pc[TAG_W+1:2] ^ 4'h9;
   endfunction

   // One cycle: drive, compare the pre-edge view with the model, clock, update the model.
   task automatic step(input logic rn, input logic fl, input logic iv, input logic [31:0] pc,
                       input logic ordy);
      logic [31:0] exp_pc;
      logic [31:0] exp_ins;
      logic [31:0] exp_tag;
      bit          do_push;
      bit          do_pop;
      resetn    = rn;
      flush     = fl;
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = instr_of(pc);
      in_tag    = tag_of(pc);
      out_ready = ordy;
      #1;
      if (check_en) begin
         exp_pc  = (sb.size() == 0) ? RPC   : sb[0].pc;
         exp_ins = (sb.size() == 0) ? 32'h0 : sb[0].instr;
         exp_tag = (sb.size() == 0) ? 32'h0 : 32'(sb[0].tag);
         chk("count", 32'(count), 32'(sb.size()));
         chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
         chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
         chk("out_pc", out_pc, exp_pc);
         chk("out_pcplus4", out_pcplus4, exp_pc + 32'd4);
         chk("out_instr", out_instr, exp_ins);
         chk("out_tag", 32'(out_tag), exp_tag);
      end
      do_push = iv && (sb.size() < DEPTH);
      do_pop  = ordy && (sb.size() != 0);
      @(posedge clk);
      #1;
      if (!rn || fl) begin
         sb.delete();
      end else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back('{pc: pc, instr: instr_of(pc), tag: tag_of(pc)});
      end
      check_en = 1'b1;
   endtask

   initial begin
      logic [31:0] npc;
      checks   = 0;
      errors   = 0;
      check_en = 1'b0;
      @(posedge clk);
      #1;

      // Reset for two cycles, then confirm the empty view.
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_pc", out_pc, 32'hbfc00000);
      chk("rst_out_instr", out_instr, 32'h0);

      // Fill with decode stalled; fifth push must be refused.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i * 4), 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h110, 1'b0);
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_head", out_pc, 32'h100);
      chk("full_pcplus4", out_pcplus4, 32'h104);

      // Drain while fetching: pointers wrap, order preserved.
      npc = 32'h110;
      for (int i = 0; i < 8; i++) begin
         bit acc;
         acc = (sb.size() < DEPTH);
         step(1'b1, 1'b0, 1'b1, npc, 1'b1);
         if (acc) npc = npc + 32'd4;
      end

      // Pop down to two entries, then push+pop together.
      while (sb.size() > 2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 32'h200, 1'b1);
      chk("simul_count", 32'(count), 32'd2);
      step(1'b1, 1'b0, 1'b1, 32'h204, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h208, 1'b0);
      chk("refill_count", 32'(count), 32'd4);
      step(1'b1, 1'b0, 1'b1, 32'h20c, 1'b1);
      chk("full_pushpop_count", 32'(count), 32'd3);

      // Flush with a concurrent push and pop.
      step(1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // Reset together with flush, with entries present.
      step(1'b1, 1'b0, 1'b1, 32'h400, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h404, 1'b0);
      step(1'b0, 1'b1, 1'b1, 32'h408, 1'b1);
      chk("rstflush_count", 32'(count), 32'd0);
      chk("rstflush_in_ready", 32'(in_ready), 32'd1);

      // PC+4 wraps at the top of the address space.
      step(1'b1, 1'b0, 1'b1, 32'hfffffffc, 1'b0);
      chk("wrap_pc", out_pc, 32'hfffffffc);
      chk("wrap_pcplus4", out_pcplus4, 32'h00000000);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
